// File: rtl/seven_seg_pkg.sv
// Shared types and segment patterns for the seven-segment display path.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  // Bit order within a pattern: bit6=a ... bit0=g, 1=lit.
  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam seg_t SEG_0     = 7'h7E;
  localparam seg_t SEG_1     = 7'h30;
  localparam seg_t SEG_2     = 7'h6D;
  localparam seg_t SEG_3     = 7'h79;
  localparam seg_t SEG_4     = 7'h33;
  localparam seg_t SEG_5     = 7'h5B;
  localparam seg_t SEG_6     = 7'h5F;
  localparam seg_t SEG_7     = 7'h70;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h7B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with inter-digit blanking and
// a shadow/display double buffer that only commits at frame boundaries.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned ON_CYCLES      = 50000,
  parameter int unsigned BLANK_CYCLES   = 500,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [7*NUM_DIGITS-1:0] digits_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int unsigned CNT_MAX = ((ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES) - 1;
  localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  // Output values that mean "everything dark" after polarity is applied.
  localparam logic [6:0]            SEG_OFF = SEG_BLANK ^ {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  scan_state_t                   state, state_n;
  logic [IDX_W-1:0]              idx, idx_n;
  logic [CNT_W-1:0]              cnt, cnt_n;
  seg_t [NUM_DIGITS-1:0]         shadow, shadow_n;
  seg_t [NUM_DIGITS-1:0]         display, display_n;
  logic                          pending_n;
  logic                          frame_done_n;
  logic                          commit;
  logic [6:0]                    seg_n;
  logic [NUM_DIGITS-1:0]         an_n;

  // State, counters, buffers and all outputs register together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      shadow     <= '0;
      display    <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      seg_out    <= SEG_OFF;
      an_out     <= AN_OFF;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      shadow     <= shadow_n;
      display    <= display_n;
      pending    <= pending_n;
      frame_done <= frame_done_n;
      seg_out    <= seg_n;
      an_out     <= an_n;
    end
  end

  assign digit_idx = idx;

  // Scan sequencing, buffer commit and next output values.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    cnt_n        = cnt;
    shadow_n     = shadow;
    display_n    = display;
    pending_n    = pending;
    frame_done_n = 1'b0;
    commit       = 1'b0;
    seg_n        = SEG_OFF;
    an_n         = AN_OFF;

    case (state)
      IDLE: begin
        if (en) begin
          state_n = BLANK;
          idx_n   = '0;
          cnt_n   = '0;
          commit  = 1'b1;
        end
      end
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_n = SHOW;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      SHOW: begin
        if (cnt == ON_LAST) begin
          state_n = BLANK;
          cnt_n   = '0;
          if (idx == IDX_LAST) begin
            idx_n        = '0;
            frame_done_n = 1'b1;
            commit       = 1'b1;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
        cnt_n   = '0;
      end
    endcase

    // Disable overrides the scan but leaves the buffers alone.
    if (!en) begin
      state_n      = IDLE;
      idx_n        = '0;
      cnt_n        = '0;
      frame_done_n = 1'b0;
      commit       = 1'b0;
    end

    // A load landing on a commit goes straight to the display.
    if (load) begin
      shadow_n = digits_in;
    end
    if (commit) begin
      if (load) begin
        display_n = digits_in;
      end else if (pending) begin
        display_n = shadow;
      end
      pending_n = 1'b0;
    end else if (load) begin
      pending_n = 1'b1;
    end

    if (state_n == SHOW) begin
      seg_n = display_n[idx_n] ^ {7{SEG_ACTIVE_LOW}};
      an_n  = AN_OFF;
      an_n[idx_n] = ~AN_ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: a vector table over the scan
// timeline plus hand sequences for disable and reset corners. A second
// instance with inverted polarity runs on the same stimulus.
module tb_seven_seg_scan_driver;
  import seven_seg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [27:0] digits_in;

  logic [6:0]  seg_out,    seg_out_i;
  logic [3:0]  an_out,     an_out_i;
  logic [1:0]  digit_idx,  digit_idx_i;
  logic        frame_done, frame_done_i;
  logic        pending,    pending_i;

  int n_cmp = 0;
  int n_bad = 0;
  int k     = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .ON_CYCLES(4), .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .digits_in(digits_in),
    .seg_out(seg_out), .an_out(an_out), .digit_idx(digit_idx),
    .frame_done(frame_done), .pending(pending)
  );

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .ON_CYCLES(4), .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut_inv (
    .clk(clk), .rst(rst), .en(en), .load(load), .digits_in(digits_in),
    .seg_out(seg_out_i), .an_out(an_out_i), .digit_idx(digit_idx_i),
    .frame_done(frame_done_i), .pending(pending_i)
  );

  typedef struct {
    int          k;     // edge number after en rose, checked just after it
    logic        ld;    // load sampled on that edge
    logic [27:0] data;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  idx;
    logic        fd;
    logic        pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int kk, input logic ld, input logic [27:0] d,
                              input logic [6:0] s, input logic [3:0] a,
                              input logic [1:0] i, input logic f, input logic p);
    vec_t v;
    v.k = kk; v.ld = ld; v.data = d; v.seg = s; v.an = a;
    v.idx = i; v.fd = f; v.pend = p;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %0h, expected %0h", nm, tag, act, exp);
    end
  endtask

  // Checks both instances; the inverted one expects the complemented drive.
  task automatic chk_all(input int tag, input logic [6:0] s, input logic [3:0] a,
                         input logic [1:0] i, input logic f, input logic p);
    logic [6:0] s_inv;
    logic [3:0] a_inv;
    s_inv = ~s;
    a_inv = ~a;
    chk("seg_out",      tag, 32'(seg_out),      32'(s));
    chk("an_out",       tag, 32'(an_out),       32'(a));
    chk("digit_idx",    tag, 32'(digit_idx),    32'(i));
    chk("frame_done",   tag, 32'(frame_done),   32'(f));
    chk("pending",      tag, 32'(pending),      32'(p));
    chk("inv_seg_out",  tag, 32'(seg_out_i),    32'(s_inv));
    chk("inv_an_out",   tag, 32'(an_out_i),     32'(a_inv));
    chk("inv_digit_idx",tag, 32'(digit_idx_i),  32'(i));
    chk("inv_frame_done",tag,32'(frame_done_i), 32'(f));
    chk("inv_pending",  tag, 32'(pending_i),    32'(p));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] d0;
    logic [27:0] d4;
    d0 = {SEG_3, SEG_2, SEG_1, SEG_0};   // 79 6D 30 7E, digit 0 in the low bits
    d4 = {SEG_4, SEG_4, SEG_4, SEG_4};   // 0x33 everywhere

    // Frame 1: first frame after enable, frame_done at edge 25.
    vecs.push_back(mk( 1, 0, '0, 7'h00, 4'b0000, 2'd0, 0, 0));
    vecs.push_back(mk( 2, 0, '0, 7'h00, 4'b0000, 2'd0, 0, 0));
    vecs.push_back(mk( 3, 0, '0, 7'h7E, 4'b0001, 2'd0, 0, 0));
    vecs.push_back(mk( 6, 0, '0, 7'h7E, 4'b0001, 2'd0, 0, 0));
    vecs.push_back(mk( 7, 0, '0, 7'h00, 4'b0000, 2'd1, 0, 0));
    vecs.push_back(mk( 9, 0, '0, 7'h30, 4'b0010, 2'd1, 0, 0));
    vecs.push_back(mk(15, 0, '0, 7'h6D, 4'b0100, 2'd2, 0, 0));
    vecs.push_back(mk(21, 0, '0, 7'h79, 4'b1000, 2'd3, 0, 0));
    vecs.push_back(mk(24, 0, '0, 7'h79, 4'b1000, 2'd3, 0, 0));
    vecs.push_back(mk(25, 0, '0, 7'h00, 4'b0000, 2'd0, 1, 0));
    vecs.push_back(mk(26, 0, '0, 7'h00, 4'b0000, 2'd0, 0, 0));
    vecs.push_back(mk(27, 0, '0, 7'h7E, 4'b0001, 2'd0, 0, 0));
    // Frame 2: load during digit 1 SHOW waits for the frame boundary.
    vecs.push_back(mk(34, 1, d4, 7'h30, 4'b0010, 2'd1, 0, 1));
    vecs.push_back(mk(39, 0, '0, 7'h6D, 4'b0100, 2'd2, 0, 1));
    vecs.push_back(mk(45, 0, '0, 7'h79, 4'b1000, 2'd3, 0, 1));
    vecs.push_back(mk(48, 0, '0, 7'h79, 4'b1000, 2'd3, 0, 1));
    vecs.push_back(mk(49, 0, '0, 7'h00, 4'b0000, 2'd0, 1, 0));
    vecs.push_back(mk(51, 0, '0, 7'h33, 4'b0001, 2'd0, 0, 0));
    vecs.push_back(mk(57, 0, '0, 7'h33, 4'b0010, 2'd1, 0, 0));
    // Frame 3 -> 4: load sampled on the commit edge goes straight in.
    vecs.push_back(mk(72, 0, '0, 7'h33, 4'b1000, 2'd3, 0, 0));
    vecs.push_back(mk(73, 1, d0, 7'h00, 4'b0000, 2'd0, 1, 0));
    vecs.push_back(mk(75, 0, '0, 7'h7E, 4'b0001, 2'd0, 0, 0));
    vecs.push_back(mk(81, 0, '0, 7'h30, 4'b0010, 2'd1, 0, 0));

    rst = 1'b1; en = 1'b0; load = 1'b0; digits_in = '0;
    tick();
    tick();
    chk_all(-1, 7'h00, 4'b0000, 2'd0, 0, 0);

    // Load while idle: held in the shadow until the first frame starts.
    rst = 1'b0;
    digits_in = d0;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk_all(-2, 7'h00, 4'b0000, 2'd0, 0, 1);
    tick();

    k  = 0;
    en = 1'b1;
    foreach (vecs[n]) begin
      while (k < vecs[n].k - 1) tick();
      if (vecs[n].ld) begin
        digits_in = vecs[n].data;
        load = 1'b1;
      end
      tick();
      load = 1'b0;
      chk_all(vecs[n].k, vecs[n].seg, vecs[n].an, vecs[n].idx, vecs[n].fd, vecs[n].pend);
    end

    // Drop en during digit 2 SHOW, hold it low for 5 edges, then resume.
    while (k < 87) tick();
    chk_all(87, 7'h6D, 4'b0100, 2'd2, 0, 0);
    en = 1'b0;
    tick();
    chk_all(88, 7'h00, 4'b0000, 2'd0, 0, 0);
    repeat (4) tick();
    chk_all(92, 7'h00, 4'b0000, 2'd0, 0, 0);
    en = 1'b1;
    tick();
    chk_all(93, 7'h00, 4'b0000, 2'd0, 0, 0);
    tick();
    chk_all(94, 7'h00, 4'b0000, 2'd0, 0, 0);
    tick();
    chk_all(95, 7'h7E, 4'b0001, 2'd0, 0, 0);

    // Reset during SHOW with a coincident load: reset wins, display cleared.
    rst = 1'b1;
    digits_in = d4;
    load = 1'b1;
    tick();
    rst = 1'b0;
    load = 1'b0;
    chk_all(96, 7'h00, 4'b0000, 2'd0, 0, 0);
    tick();
    chk_all(97, 7'h00, 4'b0000, 2'd0, 0, 0);
    tick();
    tick();
    chk_all(99, 7'h00, 4'b0001, 2'd0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
